// File: rtl/entrada_teclado.sv
// entrada_teclado: keypad capture into a 3-digit BCD buffer with a validated load strobe
module entrada_teclado #(
  parameter int NKEYS = 10,
  parameter int DIG_W = 4
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [NKEYS-1:0] teclado,
  input  logic             btn_load,
  input  logic             btn_clear,
  input  logic             en_entrada,
  output logic [DIG_W-1:0] unidades,
  output logic [DIG_W-1:0] dezenas,
  output logic [DIG_W-1:0] minutos,
  output logic             loadn,
  output logic             erro,
  output logic [1:0]       n_digitos
);
  typedef enum logic [1:0] {IDLE, ENTRADA, CARGA} state_t;
  state_t state;
  logic key_q, load_q, clear_q;
  logic key_any, key_ev, load_ev, clear_ev, one_hot;
  logic [DIG_W-1:0] v;
  assign key_any  = |teclado;
  assign key_ev   = key_any & ~key_q;
  assign load_ev  = btn_load & ~load_q;
  assign clear_ev = btn_clear & ~clear_q;
  assign one_hot  = $onehot(teclado);
  // encode the pressed key into its BCD value (only used when exactly one key is down)
  always_comb begin
    v = '0;
    for (int i = 0; i < NKEYS; i++)
      if (teclado[i]) v = DIG_W'(i);
  end
  // entry FSM: clear beats load beats key; strobes default inactive every cycle
  always_ff @(posedge clk) begin
    if (!clrn) begin
      state     <= IDLE;
      unidades  <= '0;
      dezenas   <= '0;
      minutos   <= '0;
      n_digitos <= '0;
      loadn     <= 1'b1;
      erro      <= 1'b0;
      key_q     <= 1'b0;
      load_q    <= 1'b0;
      clear_q   <= 1'b0;
    end else begin
      key_q   <= key_any;
      load_q  <= btn_load;
      clear_q <= btn_clear;
      loadn   <= 1'b1;
      erro    <= 1'b0;
      if (state == CARGA || clear_ev) begin
        state     <= IDLE;
        unidades  <= '0;
        dezenas   <= '0;
        minutos   <= '0;
        n_digitos <= '0;
      end else if (en_entrada && load_ev && state == ENTRADA) begin
        if (dezenas <= DIG_W'(5)) begin
          state <= CARGA;
          loadn <= 1'b0;
        end else begin
          erro <= 1'b1;
        end
      end else if (en_entrada && key_ev) begin
        if (one_hot) begin
          minutos   <= dezenas;
          dezenas   <= unidades;
          unidades  <= v;
          n_digitos <= (n_digitos == 2'd3) ? 2'd3 : n_digitos + 2'd1;
          state     <= ENTRADA;
        end else begin
          erro <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_entrada_teclado.sv
// tb_entrada_teclado: scoreboard bench with a decimal-arithmetic reference model
module tb_entrada_teclado;
  localparam int NK = 10;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic          clrn = 1'b0;
  logic [NK-1:0] teclado = '0;
  logic          btn_load = 1'b0, btn_clear = 1'b0, en_entrada = 1'b1;
  logic [3:0]    unidades, dezenas, minutos;
  logic          loadn, erro;
  logic [1:0]    n_digitos;

  entrada_teclado #(.NKEYS(NK), .DIG_W(4)) dut (
    .clk(clk), .clrn(clrn), .teclado(teclado), .btn_load(btn_load),
    .btn_clear(btn_clear), .en_entrada(en_entrada), .unidades(unidades),
    .dezenas(dezenas), .minutos(minutos), .loadn(loadn), .erro(erro),
    .n_digitos(n_digitos)
  );

  // expected {unidades, dezenas, minutos, loadn, erro, n_digitos} after each edge
  logic [15:0] q[$];
  logic [15:0] exp_v, act_v;
  int compared = 0, mismatched = 0;

  // model: the buffer is the 3-digit decimal number entered so far
  int val = 0, cnt = 0;
  bit loading = 0, pk = 0, pl = 0, pc = 0;

  task automatic cyc(input logic [NK-1:0] k, input bit ld, input bit cl, input bit en, input bit rn);
    bit kev, lev, cev, el, ee;
    int idx;
    @(negedge clk);
    teclado = k; btn_load = ld; btn_clear = cl; en_entrada = en; clrn = rn;
    el = 1; ee = 0;
    if (!rn) begin
      val = 0; cnt = 0; loading = 0; pk = 0; pl = 0; pc = 0;
    end else begin
      kev = (k != 0) && !pk;
      lev = ld && !pl;
      cev = cl && !pc;
      if (loading || cev) begin
        val = 0; cnt = 0; loading = 0;
      end else if (en && lev && cnt > 0) begin
        if ((val / 10) % 10 <= 5) begin loading = 1; el = 0; end
        else ee = 1;
      end else if (en && kev) begin
        if ($countones(k) == 1) begin
          idx = 0;
          for (int i = 0; i < NK; i++) if (k[i]) idx = i;
          val = (val * 10 + idx) % 1000;
          cnt = (cnt < 3) ? cnt + 1 : 3;
        end else ee = 1;
      end
      pk = (k != 0); pl = ld; pc = cl;
    end
    q.push_back({4'(val % 10), 4'((val / 10) % 10), 4'(val / 100), el, ee, 2'(cnt)});
  endtask

  task automatic press(input int key);
    cyc(NK'(1) << key, 0, 0, 1, 1);
    cyc('0, 0, 0, 1, 1);
  endtask

  task automatic load_pulse();
    cyc('0, 1, 0, 1, 1);
    cyc('0, 0, 0, 1, 1);
    cyc('0, 0, 0, 1, 1);
  endtask

  // monitor: compares each registered output snapshot against the queued expectation
  initial forever begin
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      exp_v = q.pop_front();
      act_v = {unidades, dezenas, minutos, loadn, erro, n_digitos};
      compared++;
      if (act_v !== exp_v) begin
        mismatched++;
        $display("FAIL outputs t=%0t: got m:d:u=%0d:%0d:%0d loadn=%b erro=%b n=%0d, expected m:d:u=%0d:%0d:%0d loadn=%b erro=%b n=%0d",
                 $time, act_v[7:4], act_v[11:8], act_v[15:12], act_v[3], act_v[2], act_v[1:0],
                 exp_v[7:4], exp_v[11:8], exp_v[15:12], exp_v[3], exp_v[2], exp_v[1:0]);
      end
    end
  end

  initial begin
    logic [NK-1:0] k;
    bit ld, cl, en, rn;
    int r;
    cyc('0, 0, 0, 1, 0);
    cyc('0, 0, 0, 1, 0);
    press(1); press(3); press(0);
    load_pulse();
    press(2); press(7); press(5);
    load_pulse();
    press(0);
    load_pulse();
    cyc(NK'((1 << 4) | (1 << 6)), 0, 0, 1, 1);
    cyc('0, 0, 0, 1, 1);
    repeat (20) cyc(NK'(1) << 8, 0, 0, 1, 1);
    cyc('0, 0, 0, 1, 1);
    press(1); press(2); press(3); press(4);
    cyc('0, 1, 1, 1, 1);
    cyc('0, 0, 0, 1, 1);
    press(6);
    cyc(NK'(1) << 5, 0, 0, 0, 1);
    cyc('0, 1, 0, 0, 1);
    cyc('0, 0, 0, 0, 1);
    press(7);
    cyc('0, 0, 0, 1, 0);
    cyc('0, 0, 0, 1, 1);
    k = '0; ld = 0; cl = 0; en = 1; rn = 1;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom % 3 == 0) begin
        r = int'($urandom % 10);
        k = (r < 4) ? '0 : (r < 9) ? NK'(1) << ($urandom % NK) : NK'($urandom);
      end
      ld = ($urandom % 5 == 0);
      cl = ($urandom % 40 == 0);
      en = ($urandom % 8 != 0);
      rn = ($urandom % 250 != 0);
      cyc(k, ld, cl, en, rn);
    end
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() > 0) begin
      mismatched++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
